instr_fetch: RTL

Instruction fetch and prefetch buffer that sits directly upstream of the decode/execute state machine. It streams 32-bit instruction words out of the synchronous program memory, tags each word with its PC, and holds them in a small FIFO. The decoder consumes them over a valid/ready handshake. A redirect input flushes the buffer and restarts fetch at a new PC, for jumps and branches.

---
 rtl/instr_fetch_if.sv | 47 ++++
 rtl/instr_fetch.sv | 110 +++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Bus bundle for the instruction fetch unit: program-memory read port,
// decoder valid/ready handshake, redirect request and debug/status outputs.
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    // program memory side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    // decoder side
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    // control flow redirect
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    // status
    logic [ADDR_W-1:0] fetch_pc;
    logic [LW-1:0]     level;

    // the fetch unit itself
    modport master (
        output mem_addr, mem_re,
        input  mem_rdata,
        output instr, instr_pc, instr_valid,
        input  instr_ready,
        input  redirect, redirect_pc,
        output fetch_pc, level
    );

    // memory / decoder environment
    modport slave (
        input  mem_addr, mem_re,
        output mem_rdata,
        input  instr, instr_pc, instr_valid,
        output instr_ready,
        output redirect, redirect_pc,
        input  fetch_pc, level
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch and prefetch buffer. Streams words from a synchronous
// program memory (one-cycle read latency) into a DEPTH-entry FIFO of
// {word, pc} pairs consumed by the decoder. A redirect flushes the buffer
// and restarts fetch at a new PC; a read still returning is discarded.
module instr_fetch #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW:0]       DEPTH_L = (LW+1)'(DEPTH);
    localparam logic [PW-1:0]     PTR_ONE = PW'(1);
    localparam logic [LW-1:0]     CNT_ONE = LW'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] issued_pc_r;
    logic              inflight_r;
    logic              kill_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [LW-1:0]     count_r;
    logic [31:0]       word_r [DEPTH];
    logic [ADDR_W-1:0] pc_r   [DEPTH];

    logic [LW:0]       occ_s;
    logic              valid_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;

    // Issue/push/pop decisions; free space ignores a same-cycle pop so the
    // FIFO can never overflow when the in-flight word lands.
    always_comb begin
        occ_s   = {1'b0, count_r} + {{LW{1'b0}}, inflight_r};
        valid_s = (count_r != {LW{1'b0}});
        issue_s = !reset && !bus.redirect && (occ_s < DEPTH_L);
        push_s  = inflight_r && !kill_r && !bus.redirect;
        pop_s   = valid_s && bus.instr_ready;
    end

    // Fetch address, in-flight tracking and stale-return kill flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r  <= {ADDR_W{1'b0}};
            issued_pc_r <= {ADDR_W{1'b0}};
            inflight_r  <= 1'b0;
            kill_r      <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (bus.redirect) begin
                fetch_pc_r <= bus.redirect_pc;
                kill_r     <= inflight_r;
            end else begin
                kill_r <= 1'b0;
                if (issue_s) begin
                    fetch_pc_r  <= fetch_pc_r + PC_ONE;
                    issued_pc_r <= fetch_pc_r;
                end
            end
        end
    end

    // FIFO pointers and occupancy; redirect flushes everything.
    always_ff @(posedge clk) begin
        if (reset || bus.redirect) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: returning word tagged with the address it was read from.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_r[i] <= 32'h0000_0000;
                pc_r[i]   <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            word_r[wr_ptr_r] <= bus.mem_rdata;
            pc_r[wr_ptr_r]   <= issued_pc_r;
        end
    end

    assign bus.mem_re      = issue_s;
    assign bus.mem_addr    = fetch_pc_r;
    assign bus.fetch_pc    = fetch_pc_r;
    assign bus.level       = count_r;
    assign bus.instr_valid = valid_s;
    assign bus.instr       = word_r[rd_ptr_r];
    assign bus.instr_pc    = pc_r[rd_ptr_r];
endmodule
